// File: rtl/serial_fa_sched.sv
`timescale 1ns/1ps
// serial_fa_sched
// Bit-serial adder controller. A single full-adder cell is stepped over
// WIDTH clock cycles, LSB first. Bits below APPROX_BITS use the approximate
// cell when the request carried approx_en; every other bit uses the exact
// cell. Valid/ready handshakes on both sides.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   request valid
//   in_ready   high in IDLE only
//   a, b       operands (WIDTH bits)
//   cin        carry into bit 0
//   approx_en  enable approximate cell for bits below APPROX_BITS
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts result
//   sum        result sum (WIDTH bits), held until the next DONE
//   cout       carry out of bit WIDTH-1, held like sum
//   busy       high in RUN or DONE
module serial_fa_sched #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(WIDTH - 1);
  localparam logic [IW-1:0] APPROX_LIM = IW'(APPROX_BITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [IW-1:0]    r_bit_idx;
  logic             r_approx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_x;
  logic             w_y;
  logic             w_c;
  logic             w_use_approx;
  logic             w_s_exact;
  logic             w_co_exact;
  logic             w_s_apx;
  logic             w_co_apx;
  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_sh_next;

  assign w_x = r_a_sh[0];
  assign w_y = r_b_sh[0];
  assign w_c = r_carry;

  assign w_s_exact  = w_x ^ w_y ^ w_c;
  assign w_co_exact = (w_x & w_y) | (w_x & w_c) | (w_y & w_c);
  // Approximate cell: only differs from exact at (1,1,0) and (1,1,1).
  assign w_co_apx   = w_c & (w_x | w_y);
  assign w_s_apx    = (w_x | w_y | w_c) & ~w_co_apx;

  assign w_use_approx = r_approx && (r_bit_idx < APPROX_LIM);
  assign w_s  = w_use_approx ? w_s_apx  : w_s_exact;
  assign w_co = w_use_approx ? w_co_apx : w_co_exact;

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_sh_next = w_s;
    end else begin : g_sum_wn
      assign w_sum_sh_next = {w_s, r_sum_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_sum_sh  <= '0;
      r_carry   <= 1'b0;
      r_bit_idx <= '0;
      r_approx  <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh    <= a;
            r_b_sh    <= b;
            r_carry   <= cin;
            r_approx  <= approx_en;
            r_sum_sh  <= '0;
            r_bit_idx <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_a_sh    <= r_a_sh >> 1;
          r_b_sh    <= r_b_sh >> 1;
          r_sum_sh  <= w_sum_sh_next;
          r_carry   <= w_co;
          r_bit_idx <= r_bit_idx + IW'(1);
          if (r_bit_idx == LAST_IDX) begin
            // Result registers load only here so they stay frozen through
            // DONE and keep the last result while idle.
            r_sum   <= w_sum_sh_next;
            r_cout  <= w_co;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_serial_fa_sched.sv
`timescale 1ns/1ps
module tb_serial_fa_sched;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       approx_en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;

  int checks = 0;
  int errors = 0;

  serial_fa_sched #(.WIDTH(8), .APPROX_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .approx_en(approx_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one request, check latency and result, then retire it.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tc, input logic tap,
                        input logic [7:0] exp_sum, input logic exp_cout);
    int n;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_; cin = tc; approx_en = tap; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    $display("op %s a=%02h b=%02h cin=%0b apx=%0b -> sum=%02h cout=%0b", tag, ta, tb_, tc, tap, sum, cout);
  endtask

  initial begin
    int k;
    int r;
    int acc [2];
    logic [8:0] res [2];

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    approx_en = 1'b0; out_ready = 1'b0;
    #1;
    chk("reset_state", {28'd0, in_ready, out_valid, busy, cout}, 32'b1000);
    chk("reset_sum", 32'(sum), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    run_op("exact_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
    run_op("exact_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op("apx_0f_01",   8'h0F, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b0);
    run_op("apx_07_07",   8'h07, 8'h07, 1'b1, 1'b1, 8'h08, 1'b0);
    run_op("apx_f0_f0",   8'hF0, 8'hF0, 1'b0, 1'b1, 8'hE0, 1'b1);
    run_op("exact_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);

    // Backpressure: hold DONE for 5 cycles, pulse an ignored in_valid.
    a = 8'h12; b = 8'h34; cin = 1'b1; approx_en = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {22'd0, out_valid, in_ready, cout, sum}, {22'd0, 1'b1, 1'b0, 1'b0, 8'h47});
      in_valid = (i == 2);
      a = 8'hAA; b = 8'hAA;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", {29'd0, in_ready, out_valid, busy}, 32'b100);
    tick();
    chk("bp_no_capture", {30'd0, busy, sum == 8'h47}, 32'b01);
    $display("op backpressure sum=%02h cout=%0b", sum, cout);

    // Reset in the middle of RUN at bit_idx == 3.
    a = 8'h01; b = 8'h01; cin = 1'b0; approx_en = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("midrun_reset_ctl", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("midrun_reset_res", {23'd0, cout, sum}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op("after_reset", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1;
    a = 8'h5A; b = 8'h3C; cin = 1'b0; approx_en = 1'b0; in_valid = 1'b1;
    k = 0; r = 0; acc[0] = 0; acc[1] = 0; res[0] = '0; res[1] = '0;
    for (int i = 0; i < 40 && r < 2; i++) begin
      if (in_valid && in_ready && k < 2) begin
        acc[k] = i;
        k++;
      end
      if (out_valid && r < 2) begin
        res[r] = {cout, sum};
        r++;
      end
      tick();
      if (k == 1) begin
        a = 8'h0F; b = 8'h01; approx_en = 1'b1;
      end else if (k == 2) begin
        in_valid = 1'b0;
      end
    end
    chk("b2b_accepts", 32'(k), 32'd2);
    chk("b2b_results", 32'(r), 32'd2);
    chk("b2b_interval", 32'(acc[1] - acc[0]), 32'd10);
    chk("b2b_res0", 32'(res[0]), {23'd0, 1'b0, 8'h96});
    chk("b2b_res1", 32'(res[1]), {23'd0, 1'b0, 8'h0F});
    $display("op back_to_back interval=%0d res0=%03h res1=%03h", acc[1] - acc[0], res[0], res[1]);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_fa_sched.md
Name: serial_fa_sched

Overview:
- Bit-serial adder controller that sequences a single full-adder cell over WIDTH clock cycles, one bit per cycle, LSB first.
- Per bit, it selects between the approximate full-adder function and the exact full-adder function. Bits below APPROX_BITS use the approximate cell when the request has approx_en set; all other bits use the exact cell.
- Provides valid/ready handshakes on input and output, so it sits between an operand producer and a result consumer in the approximate-arithmetic evaluation datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 1.
- APPROX_BITS, 4, number of LSBs eligible for the approximate cell; legal range 0..WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- approx_en  input  1  enable the approximate cell for bits below APPROX_BITS.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result sum.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Cell functions, with inputs x, y and carry c:
  - Exact: s = x^y^c; co = majority(x,y,c).
  - Approximate: co = c&(x|y); s = (x|y|c)&~co.
  - Approximate cell differs from exact only at (1,1,0) → s=1,co=0 and at (1,1,1) → s=0,co=1.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, capture a, b, cin and approx_en; clear bit_idx to 0; go to RUN.
  - RUN: in_ready=0. Each cycle:
    - Apply cell to a_sh[0], b_sh[0], carry_q. Use the approximate cell iff approx_en_q && bit_idx < APPROX_BITS.
    - Shift a_sh and b_sh right by 1.
    - Shift the cell's s into the MSB of sum_sh (right shift).
    - carry_q ← co; bit_idx ← bit_idx+1.
    - After the cycle with bit_idx == WIDTH-1, go to DONE.
  - DONE: out_valid=1; sum=sum_sh; cout=carry_q. On out_valid&out_ready, go to IDLE on the next edge.
- Latency:
  - Handshake at edge 0, so RUN occupies edges 1..WIDTH.
  - out_valid is high after edge WIDTH.
  - Minimum interval between accepts: WIDTH+2 cycles.
- No request is accepted in DONE, even if out_ready is high in the same cycle; the next request is accepted from IDLE.
- in_valid in RUN/DONE is ignored, and no operand is captured.
- sum and cout stay stable for the whole time out_valid is high. They hold their last value after the transfer until the next DONE.
- Width rules:
  - bit_idx is $clog2(WIDTH+1) bits wide; there is no wrap within an operation.
  - APPROX_BITS=0 forces all-exact operation; APPROX_BITS=WIDTH makes every bit approximate when approx_en is set.
  - The sum is exactly WIDTH bits; overflow appears only on cout.
- Reset, including mid-RUN or mid-DONE:
  - State=IDLE; in_ready=1; out_valid=0; busy=0.
  - sum, cout, carry_q, bit_idx and the shift registers = 0.
  - Any in-flight operation is discarded and no result is produced.
- Handshake inputs are sampled only on clock edges. The design must not combinationally depend on out_ready for any output other than the state transition.

Test Plan:
- Exact path, WIDTH=8, approx_en=0:
  - a=0x5A, b=0x3C, cin=0 → sum=0x96, cout=0; out_valid rises 8 cycles after accept.
  - a=0xFF, b=0x01 → sum=0x00, cout=1.
- Approx LSBs, approx_en=1, APPROX_BITS=4:
  - a=0x0F, b=0x01, cin=0 → sum=0x0F, cout=0 (exact result would be 0x10).
  - a=0x07, b=0x07, cin=1 → sum=0x08, cout=0.
- Exact MSBs with approx_en=1: a=0xF0, b=0xF0, cin=0 → sum=0xE0, cout=1 (upper bits exact).
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid=1, sum/cout constant, in_ready=0, and a pulsed in_valid is ignored. Raise out_ready → IDLE next cycle, in_ready=1.
- Reset mid-RUN: assert rst at bit_idx=3 → outputs zero and in_ready=1 immediately. After release, a=0x01, b=0x01, approx_en=0 → sum=0x02, cout=0.
- Back-to-back: two requests with out_ready tied high → accepts are exactly WIDTH+2 cycles apart, and both results are correct.
